// File: rtl/conv_out_writer.sv
// conv_out_writer: conv output stage. Drains one LANES-wide row per channel
// group (CG) from the accumulator array into memory write beats, with
// optional residual add (saturating), 2x nearest upsample and stride-2 row
// folding. Reports completion per job sequence id.
//
// Ports:
//   clock, resetN           clock, async active-low reset
//   cfg_*                   job descriptor, accepted only in IDLE (cfg_ready)
//   src_valid/ready/data    CG rows, CG c at [c*LANES*DATA_W +: LANES*DATA_W]
//   res_valid/ready/data    residual row (used only in res mode, not in up2)
//   wr_valid/ready/addr/data  memory write beats
//   busy, done, done_seq    status; done pulses once per finished job
//
// Build option: CONV_OUT_RELU_EN clamps negative output lanes to zero.
//
// state | meaning
// IDLE  | waiting for a descriptor, cfg_ready=1
// RUN   | issuing write beats
// DONE  | one-cycle done pulse, then back to IDLE
module conv_out_writer #(
  parameter int LANES  = 16,
  parameter int DATA_W = 16,
  parameter int CG_NUM = 4,
  parameter int ADDR_W = 32,
  parameter int ROW_W  = 10,
  parameter int SEQ_W  = 8
) (
  input  logic                             clock,
  input  logic                             resetN,
  input  logic                             cfg_valid,
  output logic                             cfg_ready,
  input  logic [ADDR_W-1:0]                cfg_base,
  input  logic [ADDR_W-1:0]                cfg_frame_str,
  input  logic [ADDR_W-1:0]                cfg_row_str,
  input  logic [ROW_W-1:0]                 cfg_rows_m1,
  input  logic [$clog2(CG_NUM)-1:0]        cfg_cg_m1,
  input  logic [2:0]                       cfg_mode,
  input  logic [SEQ_W-1:0]                 cfg_seq,
  input  logic                             src_valid,
  output logic                             src_ready,
  input  logic [CG_NUM*LANES*DATA_W-1:0]   src_data,
  input  logic                             res_valid,
  output logic                             res_ready,
  input  logic [LANES*DATA_W-1:0]          res_data,
  output logic                             wr_valid,
  input  logic                             wr_ready,
  output logic [ADDR_W-1:0]                wr_addr,
  output logic [LANES*DATA_W-1:0]          wr_data,
  output logic                             busy,
  output logic                             done,
  output logic [SEQ_W-1:0]                 done_seq
);

  localparam int CG_W = $clog2(CG_NUM);
  localparam int RD   = LANES * DATA_W;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t state_q, state_d;

  logic [ADDR_W-1:0] frame_q, addr_q, row_str_q, frame_str_q, addr_off;
  logic [ROW_W-1:0]  row_q, rows_m1_q;
  logic [CG_W-1:0]   cg_q, cg_m1_q;
  logic [1:0]        step_q;
  logic              up2_q, pool_q, res_q;
  logic [SEQ_W-1:0]  seq_q, done_seq_q;
  logic [2*RD-1:0]   dbl_q, dbl_live;
  logic [RD-1:0]     cur_row, beat;
  logic              need_res, fire, row_adv, row_end, last;

  function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [DATA_W:0] s;
    s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    if (s[DATA_W] != s[DATA_W-1])
      sat_add = s[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    else
      sat_add = s[DATA_W-1:0];
  endfunction

  assign need_res  = res_q & ~up2_q;
  assign wr_valid  = (state_q == S_RUN) & src_valid & (~need_res | res_valid);
  assign fire      = wr_valid & wr_ready;
  // In up2 one input row yields four beats; only the last one consumes it.
  assign row_adv   = fire & (~up2_q | (step_q == 2'd3));
  assign row_end   = row_adv & (row_q == rows_m1_q);
  assign last      = row_end & (cg_q == cg_m1_q);
  assign src_ready = row_adv;
  assign res_ready = row_adv & need_res;
  assign cfg_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign done_seq  = done_seq_q;

  always_comb begin
    cur_row = '0;
    for (int c = 0; c < CG_NUM; c++)
      if (cg_q == CG_W'(c)) cur_row = src_data[c*RD +: RD];
    dbl_live = '0;
    for (int j = 0; j < 2*LANES; j++)
      dbl_live[j*DATA_W +: DATA_W] = cur_row[(j/2)*DATA_W +: DATA_W];
  end

  always_comb begin
    logic [DATA_W-1:0] v;
    beat = '0;
    for (int i = 0; i < LANES; i++) begin
      v = cur_row[i*DATA_W +: DATA_W];
      if (up2_q) begin
        // Step 0 reads the live row; later steps read the copy taken at step 0.
        case (step_q)
          2'd0:    v = dbl_live[i*DATA_W +: DATA_W];
          2'd1:    v = dbl_q[(LANES+i)*DATA_W +: DATA_W];
          2'd2:    v = dbl_q[i*DATA_W +: DATA_W];
          default: v = dbl_q[(LANES+i)*DATA_W +: DATA_W];
        endcase
      end else if (need_res) begin
        v = sat_add(cur_row[i*DATA_W +: DATA_W], res_data[i*DATA_W +: DATA_W]);
      end
`ifdef CONV_OUT_RELU_EN
      if (v[DATA_W-1]) v = '0;
`endif
      beat[i*DATA_W +: DATA_W] = v;
    end
  end

  assign wr_data = (state_q == S_RUN) ? beat : '0;

  always_comb begin
    case (step_q)
      2'd0:    addr_off = '0;
      2'd1:    addr_off = ADDR_W'(LANES);
      2'd2:    addr_off = row_str_q;
      default: addr_off = row_str_q + ADDR_W'(LANES);
    endcase
  end

  assign wr_addr = addr_q + addr_off;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cfg_valid) state_d = S_RUN;
      S_RUN:   if (last) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      frame_q <= '0; addr_q <= '0; row_str_q <= '0; frame_str_q <= '0;
      row_q <= '0; rows_m1_q <= '0; cg_q <= '0; cg_m1_q <= '0; step_q <= '0;
      up2_q <= 1'b0; pool_q <= 1'b0; res_q <= 1'b0;
      seq_q <= '0; done_seq_q <= '0; dbl_q <= '0;
    end else if (state_q == S_IDLE) begin
      if (cfg_valid) begin
        frame_q     <= cfg_base;
        addr_q      <= cfg_base;
        row_str_q   <= cfg_row_str;
        frame_str_q <= cfg_frame_str;
        rows_m1_q   <= cfg_rows_m1;
        cg_m1_q     <= cfg_cg_m1;
        up2_q       <= cfg_mode[2];
        pool_q      <= cfg_mode[1] & ~cfg_mode[2];
        res_q       <= cfg_mode[0];
        seq_q       <= cfg_seq;
        row_q       <= '0;
        cg_q        <= '0;
        step_q      <= '0;
      end
    end else if (state_q == S_RUN && fire) begin
      if (up2_q && step_q == 2'd0) dbl_q <= dbl_live;
      if (!row_adv) begin
        step_q <= step_q + 2'd1;
      end else begin
        step_q <= '0;
        if (row_end) begin
          row_q   <= '0;
          frame_q <= frame_q + frame_str_q;
          addr_q  <= frame_q + frame_str_q;
          if (!last) cg_q <= cg_q + CG_W'(1);
        end else begin
          row_q <= row_q + ROW_W'(1);
          if (up2_q)
            addr_q <= addr_q + {row_str_q[ADDR_W-2:0], 1'b0};
          else if (!pool_q || row_q[0])
            addr_q <= addr_q + row_str_q;
        end
        if (last) done_seq_q <= seq_q;
      end
    end
  end

endmodule
